// File: rtl/elevator_ctrl_if.sv
// Button / display bundle for the two-floor elevator controller.
// master: board side (drives calls, observes display outputs).
// slave : controller side.
//   btn_call1, btn_call2 : floor call requests
//   state                : 3-bit state code for the display driver
//   counting_value       : remaining seconds (travel or door)
//   door_open            : door open indicator
//   pending              : latched unserved calls, bit0 = floor 1, bit1 = floor 2
interface elevator_ctrl_if;
  logic       btn_call1;
  logic       btn_call2;
  logic [2:0] state;
  logic [2:0] counting_value;
  logic       door_open;
  logic [1:0] pending;

  modport master (
    output btn_call1, btn_call2,
    input  state, counting_value, door_open, pending
  );

  modport slave (
    input  btn_call1, btn_call2,
    output state, counting_value, door_open, pending
  );
endinterface

// File: rtl/elevator_ctrl.sv
// Two-floor elevator controller: latches floor calls, sequences travel and
// door timing off a 1 s prescaled tick, and presents the state code and
// countdown straight to the 7-segment display driver.
// Ports:
//   clk  : system clock
//   rst  : synchronous active-high reset
//   bus  : elevator_ctrl_if.slave (btn_call1/2 in; state, counting_value,
//          door_open, pending out, all registered)
// Parameters: TICK_DIV (cycles per second), TRAVEL_SEC (1..5), DOOR_SEC (1..5).
// Optional: define ELEV_BTN_SYNC_EN to add 2-flop synchronizers plus
// rising-edge detect on the buttons (held button = one call, +2 cycles latency).
module elevator_ctrl #(
  parameter int unsigned TICK_DIV   = 50000000,
  parameter int unsigned TRAVEL_SEC = 5,
  parameter int unsigned DOOR_SEC   = 3
) (
  input logic             clk,
  input logic             rst,
  elevator_ctrl_if.slave  bus
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
  localparam logic [2:0]    TRAVEL_LD = 3'(TRAVEL_SEC);
  localparam logic [2:0]    DOOR_LD   = 3'(DOOR_SEC);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FLOOR1 = 3'd1,
    S_FLOOR2 = 3'd2,
    S_GO1    = 3'd3,
    S_GO2    = 3'd4
  } state_t;

  state_t        state_q, state_n;
  logic [2:0]    cnt_q, cnt_n;
  logic          door_q, door_n;
  logic [1:0]    pend_q, pend_n;
  logic [PW-1:0] presc_q, presc_n;
  logic          tick;
  logic          load;
  logic [1:0]    call;

  // Call front end: {floor2, floor1}
`ifdef ELEV_BTN_SYNC_EN
  logic [1:0] sync1_q, sync2_q, sync3_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 2'b00;
      sync2_q <= 2'b00;
      sync3_q <= 2'b00;
    end else begin
      sync1_q <= {bus.btn_call2, bus.btn_call1};
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  assign call = sync2_q & ~sync3_q;
`else
  assign call = {bus.btn_call2, bus.btn_call1};
`endif

  assign tick = (presc_q == TICK_LAST);

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 3'd0;
      door_q  <= 1'b0;
      pend_q  <= 2'b00;
      presc_q <= '0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      door_q  <= door_n;
      pend_q  <= pend_n;
      presc_q <= presc_n;
    end
  end

  // Next-state, countdown and pending-call logic
  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    pend_n  = pend_q;
    load    = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Floor 1 wins a tie; the floor-2 request stays latched
        if (call[0] || pend_q[0]) begin
          state_n = S_FLOOR1;
          cnt_n   = DOOR_LD;
          load    = 1'b1;
          pend_n  = {pend_q[1] | call[1], 1'b0};
        end else if (call[1] || pend_q[1]) begin
          state_n = S_GO2;
          cnt_n   = TRAVEL_LD;
          load    = 1'b1;
          pend_n  = 2'b00;
        end else begin
          cnt_n = 3'd0;
        end
      end

      S_FLOOR1: begin
        pend_n[1] = pend_q[1] | call[1];
        if (call[0]) begin
          cnt_n = DOOR_LD;
          load  = 1'b1;
        end else if (cnt_q == 3'd0) begin
          if (pend_q[1]) begin
            state_n = S_GO2;
            cnt_n   = TRAVEL_LD;
            load    = 1'b1;
          end
        end else if (tick) begin
          cnt_n = cnt_q - 3'd1;
        end
      end

      S_FLOOR2: begin
        pend_n[0] = pend_q[0] | call[0];
        if (call[1]) begin
          cnt_n = DOOR_LD;
          load  = 1'b1;
        end else if (cnt_q == 3'd0) begin
          if (pend_q[0]) begin
            state_n = S_GO1;
            cnt_n   = TRAVEL_LD;
            load    = 1'b1;
          end
        end else if (tick) begin
          cnt_n = cnt_q - 3'd1;
        end
      end

      S_GO1: begin
        pend_n = pend_q | call;
        if (tick) begin
          // Arrive on the tick that would take the count to 0
          if (cnt_q <= 3'd1) begin
            state_n   = S_FLOOR1;
            cnt_n     = DOOR_LD;
            load      = 1'b1;
            pend_n[0] = 1'b0;
          end else begin
            cnt_n = cnt_q - 3'd1;
          end
        end
      end

      S_GO2: begin
        pend_n = pend_q | call;
        if (tick) begin
          if (cnt_q <= 3'd1) begin
            state_n   = S_FLOOR2;
            cnt_n     = DOOR_LD;
            load      = 1'b1;
            pend_n[1] = 1'b0;
          end else begin
            cnt_n = cnt_q - 3'd1;
          end
        end
      end

      default: begin
        state_n = S_IDLE;
        cnt_n   = 3'd0;
      end
    endcase

    door_n  = ((state_n == S_FLOOR1) || (state_n == S_FLOOR2)) && (cnt_n != 3'd0);
    // Any countdown load restarts the second so it lasts a full TICK_DIV
    presc_n = (load || tick) ? '0 : presc_q + PW'(1);
  end

  assign bus.state          = 3'(state_q);
  assign bus.counting_value = cnt_q;
  assign bus.door_open      = door_q;
  assign bus.pending        = pend_q;

endmodule

// File: doc/elevator_ctrl.md
Name: elevator_ctrl

Overview:
- Two-floor elevator controller FSM.
- Turns floor call buttons into the 3-bit state code and 3-bit countdown value that the 7-segment display driver consumes directly.
- Owns the 1 s timebase, travel timing and door timing.
- Sits between the board buttons and the display driver.

Parameters:
- TICK_DIV, 50000000, clock cycles per 1 s tick (sims use 4).
- TRAVEL_SEC, 5, seconds to travel between floors; legal range 1..5.
- DOOR_SEC, 3, seconds the door stays open on arrival or re-open; legal range 1..5.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- btn_call1  in  1  floor-1 call.
- btn_call2  in  1  floor-2 call.
- state  out  3  0 idle, 1 floor1, 2 floor2, 3 going_to_1, 4 going_to_2.
- counting_value  out  3  remaining seconds: travel time or door time; 0 = nothing to show.
- door_open  out  1  high while in floor1/floor2 with counting_value > 0.
- pending  out  2  latched unserved calls; bit0 = floor 1, bit1 = floor 2.

Behaviour:
- Clock and reset:
  - One clock: clk.
  - Reset is synchronous and active-high: rst.
  - On rst: state=0, counting_value=0, door_open=0, pending=2'b00, prescaler=0.
  - rst mid-travel aborts to idle. There is no retained position.
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps.
  - tick is a one-cycle pulse when prescaler == TICK_DIV-1.
  - Every load of counting_value clears the prescaler, so the first second after any load is a full TICK_DIV cycles.
- Call latching:
  - A call sets its pending bit on the next edge.
  - Exception: a call for the floor the car is currently stopped at, in floor1/floor2, sets no pending bit. It reloads counting_value=DOOR_SEC instead (door re-open).
  - Calls during travel for the destination floor are absorbed; the bit is cleared on arrival.
- IDLE (0), counting_value=0:
  - call1 → floor1, load DOOR_SEC.
  - else call2 → going_to_2, load TRAVEL_SEC.
  - Simultaneous call1+call2: call1 wins; the floor-2 pending bit is set.
- FLOOR1 (1) / FLOOR2 (2):
  - Decrement counting_value on tick while > 0, floor at 0.
  - When counting_value == 0 and the opposite-floor pending bit is set: go to going_to_2 or going_to_1 on the next edge, load TRAVEL_SEC, clear prescaler.
  - With the door closed and nothing pending, the car stays put.
  - A pending call arriving the same cycle counting_value reaches 0 departs on the following edge.
- GOING_TO_1 (3) / GOING_TO_2 (4):
  - Decrement counting_value on tick.
  - On a tick with counting_value == 1: go to the destination floor state, load DOOR_SEC, clear that floor's pending bit (same edge).
  - counting_value therefore shows TRAVEL_SEC..1 during travel and never 0.
- Outputs: all registered; no combinational path from btn_* to any output.
- Undefined encodings 5..7 recover to idle on the next edge with counting_value=0.

Optional Feature:
- Macro: ELEV_BTN_SYNC_EN.
- Defined:
  - Each btn_* passes through a 2-flop synchronizer, then rising-edge detect (third flop).
  - A held button counts as one call.
  - Response latency is 2 cycles longer than without the macro.
  - Synchronizer flops reset to 0.
- Undefined:
  - btn_* must already be synchronous one-cycle pulses.
  - The input is sampled every cycle it is high, so a held level re-asserts the call each cycle. In a floor state this repeatedly reloads DOOR_SEC.

Test Plan (TICK_DIV=4, TRAVEL_SEC=5, DOOR_SEC=3, macro undefined):
- Reset, one-cycle btn_call2 pulse → next edge state=4, counting_value=5. Value decrements every 4 cycles: 5,4,3,2,1. After 20 cycles state=2, counting_value=3, door_open=1. Then 3,2,1,0 over 12 cycles, after which door_open=0.
- At floor2 with door closed, pulse btn_call1 → pending=01. Next edge state=3, counting_value=5. On arrival state=1, pending=00.
- Pulse btn_call1 and btn_call2 in the same cycle from idle → state=1, counting_value=3, pending=10. After the door counts to 0, the next edge gives state=4, counting_value=5.
- At floor1 with counting_value=1, pulse btn_call1 → counting_value reloads to 3, door_open stays 1, and the next tick lands exactly 4 cycles later.
- Assert rst during going_to_2 with counting_value=3 → next edge state=0, counting_value=0, pending=00, door_open=0.
- With ELEV_BTN_SYNC_EN defined, hold btn_call2 high for 10 cycles from idle → exactly one call. state=4 appears 3 edges after assertion; no extra pending bit is set.
